// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer with valid/ready holding register
// Words complete on the WIDTH-th strobed bit and land directly in dout; overrun is sticky.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sin,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shifted;
  logic             complete, load, set_ovr;

  always_comb begin
    shifted = '0;
    if (LSB_FIRST)
      shifted = {sin, shreg[WIDTH-1:1]};
    else
      shifted = {shreg[WIDTH-2:0], sin};
  end

  assign complete   = en && (bit_cnt == LAST);
  assign dout_valid = (state == HOLD);

  // A completing frame may only overwrite dout if the held word is gone or leaving this edge.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    set_ovr = 1'b0;
    case (state)
      COLLECT: begin
        if (complete) begin
          state_n = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        if (complete) begin
          state_n = HOLD;
          if (dout_ready)
            load = 1'b1;
          else
            set_ovr = 1'b1;
        end else if (dout_ready) begin
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      shreg   <= '0;
      bit_cnt <= '0;
      dout    <= '0;
      overrun <= 1'b0;
    end else if (clr) begin
      state   <= COLLECT;
      shreg   <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      if (en) begin
        shreg   <= shifted;
        bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
      end
      if (load)
        dout <= shifted;
      if (set_ovr)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - scoreboard bench for sipo_deser, LSB-first and MSB-first instances
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst, clr, en, sin, dout_ready;
  logic [3:0] dout_l, dout_m;
  logic       dout_valid_l, dout_valid_m;
  logic [1:0] bit_cnt_l, bit_cnt_m;
  logic       overrun_l, overrun_m;

  int checks = 0;
  int errors = 0;

  logic [3:0] q_l[$];
  logic [3:0] q_m[$];
  logic       pv_l = 1'b0, pv_m = 1'b0, pr = 1'b0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .sin(sin),
    .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .bit_cnt(bit_cnt_l), .overrun(overrun_l)
  );

  sipo_deser #(.WIDTH(4), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .sin(sin),
    .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .bit_cnt(bit_cnt_m), .overrun(overrun_m)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic r, input logic c);
    en = e; sin = s; dout_ready = r; clr = c;
    @(posedge clk);
    #1;
    en = 1'b0; sin = 1'b0; dout_ready = 1'b0; clr = 1'b0;
  endtask

  task automatic frame(input logic [3:0] bits, input logic r_last);
    for (int i = 0; i < 4; i++)
      step(1'b1, bits[3-i], (i == 3) ? r_last : 1'b0, 1'b0);
  endtask

  // A new word is on dout when valid rises, or valid persists across an accepting edge.
  always @(negedge clk) begin
    if (rst) begin
      pv_l = 1'b0; pv_m = 1'b0; pr = 1'b0;
    end else begin
      if (dout_valid_l && (!pv_l || pr)) begin
        checks++;
        if (q_l.size() == 0) begin
          errors++;
          $display("FAIL lsb_word: unexpected word %h", dout_l);
        end else begin
          logic [3:0] e;
          e = q_l.pop_front();
          if (dout_l !== e) begin
            errors++;
            $display("FAIL lsb_word: got %h expected %h", dout_l, e);
          end
        end
      end
      if (dout_valid_m && (!pv_m || pr)) begin
        checks++;
        if (q_m.size() == 0) begin
          errors++;
          $display("FAIL msb_word: unexpected word %h", dout_m);
        end else begin
          logic [3:0] e;
          e = q_m.pop_front();
          if (dout_m !== e) begin
            errors++;
            $display("FAIL msb_word: got %h expected %h", dout_m, e);
          end
        end
      end
      pv_l = dout_valid_l; pv_m = dout_valid_m; pr = dout_ready;
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; sin = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", dout_valid_l, 0);
    chk("reset_dout", dout_l, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Bits listed in arrival order: 1,1,0,1
    q_l.push_back(4'hB); q_m.push_back(4'hD);
    frame(4'b1101, 1'b0);
    chk("t2_valid", dout_valid_l, 1);
    chk("t2_bitcnt", bit_cnt_l, 0);
    chk("t2_dout_l", dout_l, 4'hB);
    chk("t2_dout_m", dout_m, 4'hD);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_accept", dout_valid_l, 0);

    // Second frame completes on the same edge that accepts the first
    q_l.push_back(4'hA); q_m.push_back(4'h5);
    q_l.push_back(4'hC); q_m.push_back(4'h3);
    frame(4'b0101, 1'b0);
    frame(4'b0011, 1'b1);
    chk("t3_valid_kept", dout_valid_l, 1);
    chk("t3_dout", dout_l, 4'hC);
    chk("t3_no_overrun", overrun_l, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_accept", dout_valid_l, 0);

    q_l.push_back(4'hF); q_m.push_back(4'hF);
    frame(4'b1111, 1'b0);
    chk("t4_no_overrun_yet", overrun_l, 0);
    frame(4'b0000, 1'b0);
    chk("t4_overrun", overrun_l, 1);
    chk("t4_overrun_m", overrun_m, 1);
    chk("t4_dout_kept", dout_l, 4'hF);
    chk("t4_bitcnt", bit_cnt_l, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_valid_clr", dout_valid_l, 0);
    chk("t4_overrun_sticky", overrun_l, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_overrun_clr", overrun_l, 0);
    chk("t4_dout_after_clr", dout_l, 4'hF);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_bitcnt_mid", bit_cnt_l, 2);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_bitcnt_clr", bit_cnt_l, 0);
    q_l.push_back(4'h6); q_m.push_back(4'h6);
    frame(4'b0110, 1'b0);
    chk("t5_valid", dout_valid_l, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Strobe gaps: 1,0,0,1 each followed by 3 idle cycles
    q_l.push_back(4'h9); q_m.push_back(4'h9);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] b;
      b = 4'b1001;
      step(1'b1, b[3-i], 1'b0, 1'b0);
      chk("t6_bitcnt_step", bit_cnt_l, (i + 1) % 4);
      if (i < 3) begin
        chk("t6_not_valid", dout_valid_l, 0);
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_bitcnt_hold", bit_cnt_l, i + 1);
      end
    end
    chk("t6_valid", dout_valid_l, 1);
    chk("t6_dout", dout_l, 4'h9);

    // Drive into overrun with a partial frame pending, then reset between edges
    frame(4'b1010, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_pre_overrun", overrun_l, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_dout", dout_l, 0);
    chk("t1_valid", dout_valid_l, 0);
    chk("t1_bitcnt", bit_cnt_l, 0);
    chk("t1_overrun", overrun_l, 0);
    chk("t1_dout_m", dout_m, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_l.push_back(4'hE); q_m.push_back(4'h7);
    frame(4'b0111, 1'b0);
    chk("t1_after_valid", dout_valid_l, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    chk("queue_l_empty", q_l.size(), 0);
    chk("queue_m_empty", q_m.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
